// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, 1-2 stop bits.
// The baud_clk input is edge-detected in the clk domain and is never used as a clock.
module uart_tx_serializer #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_done
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
  localparam logic             ODD       = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic                 baud_prev_q, baud_prev_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_done_q, tx_done_d;
  logic                 tick_c;

  // One-cycle strobe on each rising edge of the baud level
  assign tick_c = baud_clk & ~baud_prev_q;

  always_comb begin
    state_d     = state_q;
    baud_prev_d = baud_clk;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    parity_d    = parity_q;
    tx_d        = tx_q;
    tx_ready_d  = tx_ready_q;
    tx_done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d       = 1'b1;
        tx_ready_d = 1'b1;
        // Parity is latched from the captured byte so later tx_data changes cannot leak in
        if (tx_valid && tx_ready_q) begin
          shift_d    = tx_data;
          parity_d   = (^tx_data) ^ ODD;
          tx_ready_d = 1'b0;
          state_d    = ARM;
        end
      end
      ARM: begin
        if (tick_c) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (tick_c) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick_c) begin
          if (cnt_q < LAST_DATA) begin
            cnt_d   = cnt_q + CNT_W'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end else if (PARITY_EN != 0) begin
            tx_d    = parity_q;
            state_d = PARITY;
          end else begin
            tx_d    = 1'b1;
            cnt_d   = '0;
            state_d = STOP;
          end
        end
      end
      PARITY: begin
        if (tick_c) begin
          tx_d    = 1'b1;
          cnt_d   = '0;
          state_d = STOP;
        end
      end
      STOP: begin
        // cnt_q counts elapsed stop bits; tx_ready returns one cycle after tx_done
        if (tick_c) begin
          if (cnt_q == LAST_STOP) begin
            tx_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      baud_prev_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      parity_q    <= 1'b0;
      tx_q        <= 1'b1;
      tx_ready_q  <= 1'b1;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_prev_q <= baud_prev_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      parity_q    <= parity_d;
      tx_q        <= tx_d;
      tx_ready_q  <= tx_ready_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: four parameterisations share clk, baud_clk and reset.
// baud_clk toggles every 4 clk, so each line bit lasts 8 clk.
module tb_uart_tx_serializer;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       baud_clk = 1'b0;
  logic       tx_valid [4];
  logic [7:0] tx_data  [4];
  logic       tx_w     [4];
  logic       ready_w  [4];
  logic       done_w   [4];

  int errors = 0;
  int checks = 0;
  logic exp_q[$];
  int   len_q[$];

  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dflt (
    .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_done(done_w[0]));

  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
    .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .tx_done(done_w[1]));

  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .tx_done(done_w[2]));

  uart_tx_serializer #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_d7s2 (
    .clk(clk), .reset(reset), .baud_clk(baud_clk), .tx_data(tx_data[3][6:0]), .tx_valid(tx_valid[3]),
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .tx_done(done_w[3]));

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (4) @(negedge clk);
      baud_clk = ~baud_clk;
    end
  end

  function automatic int db_of(input int s);   return (s == 3) ? 7 : 8;           endfunction
  function automatic bit pe_of(input int s);   return (s == 1) || (s == 2);       endfunction
  function automatic bit odd_of(input int s);  return (s == 2);                   endfunction
  function automatic int sb_of(input int s);   return (s == 3) ? 2 : 1;           endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line bits for one frame, from the bench's own view of the frame format
  task automatic push_frame(input int s, input logic [7:0] d);
    logic p;
    int   n;
    p = 1'b0;
    n = 1;
    exp_q.push_back(1'b0);
    for (int i = 0; i < db_of(s); i++) begin
      exp_q.push_back(d[i]);
      p = p ^ d[i];
      n++;
    end
    if (pe_of(s)) begin
      exp_q.push_back(odd_of(s) ? ~p : p);
      n++;
    end
    for (int i = 0; i < sb_of(s); i++) begin
      exp_q.push_back(1'b1);
      n++;
    end
    len_q.push_back(n);
  endtask

  // Called at a negedge; holds tx_valid until the byte is taken, then scrambles tx_data
  task automatic send(input int s, input logic [7:0] d, input bit track);
    int t;
    tx_valid[s] = 1'b1;
    tx_data[s]  = d;
    t = 0;
    while (ready_w[s] !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check_eq("accept_wait", 32'(t < 400), 32'd1);
    if (track) push_frame(s, d);
    @(negedge clk);
    tx_valid[s] = 1'b0;
    tx_data[s]  = 8'($urandom);
  endtask

  // Waits for a start bit, checks each bit for 8 samples, then the done/ready handshake
  task automatic rx_frame(input int s, output int idle);
    int   t;
    int   n;
    int   good;
    logic b;
    t = 0;
    while (tx_w[s] !== 1'b0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    idle = t;
    check_eq("start_seen", 32'(t < 400), 32'd1);
    n = (len_q.size() > 0) ? len_q.pop_front() : 0;
    for (int i = 0; i < n; i++) begin
      b = exp_q.pop_front();
      good = 0;
      for (int k = 0; k < 8; k++) begin
        if (tx_w[s] === b && ready_w[s] === 1'b0 && done_w[s] === 1'b0) good++;
        @(negedge clk);
      end
      check_eq($sformatf("dut%0d_bit%0d", s, i), 32'(good), 32'd8);
    end
    check_eq("done_pulse", 32'(done_w[s]), 32'd1);
    check_eq("done_tx", 32'(tx_w[s]), 32'd1);
    check_eq("done_ready", 32'(ready_w[s]), 32'd0);
    @(negedge clk);
    check_eq("done_width", 32'(done_w[s]), 32'd0);
    check_eq("ready_back", 32'(ready_w[s]), 32'd1);
  endtask

  initial begin
    int idle_a;
    int idle_b;
    int cnt;
    int t;
    for (int i = 0; i < 4; i++) begin
      tx_valid[i] = 1'b0;
      tx_data[i]  = 8'h00;
    end

    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      check_eq($sformatf("rst_tx%0d", s), 32'(tx_w[s]), 32'd1);
      check_eq($sformatf("rst_ready%0d", s), 32'(ready_w[s]), 32'd1);
      check_eq($sformatf("rst_done%0d", s), 32'(done_w[s]), 32'd0);
    end
    reset = 1'b0;

    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_w[0] === 1'b1 && done_w[0] === 1'b0 && ready_w[0] === 1'b1) cnt++;
    end
    check_eq("idle_quiet", 32'(cnt), 32'd30);

    send(0, 8'hA5, 1'b1);
    rx_frame(0, idle_a);
    repeat (5) @(negedge clk);

    send(1, 8'h07, 1'b1);
    rx_frame(1, idle_a);
    send(2, 8'h07, 1'b1);
    rx_frame(2, idle_a);
    repeat (5) @(negedge clk);

    // Second byte offered mid-frame must wait and follow after exactly one idle bit
    send(0, 8'h3C, 1'b1);
    fork
      begin
        rx_frame(0, idle_a);
        rx_frame(0, idle_b);
        check_eq("b2b_gap_clk", 32'(idle_b + 1), 32'd8);
      end
      begin
        repeat (20) @(negedge clk);
        send(0, 8'hC3, 1'b1);
      end
    join
    repeat (5) @(negedge clk);

    // Abort 0xFF in the middle of data bit 3
    send(0, 8'hFF, 1'b0);
    t = 0;
    while (tx_w[0] !== 1'b0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check_eq("abort_start_seen", 32'(t < 400), 32'd1);
    repeat (36) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_tx", 32'(tx_w[0]), 32'd1);
    check_eq("abort_ready", 32'(ready_w[0]), 32'd1);
    check_eq("abort_done", 32'(done_w[0]), 32'd0);
    cnt = 0;
    t = 0;
    repeat (24) begin
      @(negedge clk);
      if (done_w[0] !== 1'b0) cnt++;
      if (tx_w[0] === 1'b1) t++;
    end
    check_eq("abort_no_done", 32'(cnt), 32'd0);
    check_eq("abort_line_high", 32'(t), 32'd24);
    send(0, 8'h55, 1'b1);
    rx_frame(0, idle_a);
    repeat (5) @(negedge clk);

    send(3, 8'h41, 1'b1);
    rx_frame(3, idle_a);

    check_eq("sb_empty", 32'(exp_q.size() + len_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
